// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, memory arbiter FSM states and
// the default load value returned on a failed RAM access.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } arbstate_t;

  localparam int unsigned WORD_W           = 32;
  localparam logic [31:0] BAD_WORD_DEFAULT = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_arbiter.sv
// Serialises instruction fetches and data reads/writes onto the single
// RAM port. Data requests have strict priority; each latched access runs
// to completion (ACCESS, ERROR or wait timeout) and is answered with a
// one-cycle hit pulse in RESP.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter logic [31:0] BAD_WORD = BAD_WORD_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              iHit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dHit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memErr
);

  localparam int unsigned CNT_W    = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  arbstate_t         state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [WORD_W-1:0] load_reg;
  logic              op_write;
  logic              src_data;
  ramstate_t         rs;

  assign rs    = ramstate_t'(ramstate);
  assign iload = load_reg;
  assign dload = load_reg;

  // Arbiter FSM with registered RAM strobes, hits, load register and error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      load_reg <= '0;
      op_write <= 1'b0;
      src_data <= 1'b0;
      iHit     <= 1'b0;
      dHit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      memErr   <= 1'b0;
    end else begin
      iHit <= 1'b0;
      dHit <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dWEN || dREN) begin
            state    <= DATA;
            op_write <= dWEN;
            src_data <= 1'b1;
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
            ramaddr  <= daddr;
            ramstore <= dWEN ? dstore : '0;
          end else if (iREN) begin
            state    <= INSTR;
            op_write <= 1'b0;
            src_data <= 1'b0;
            ramWEN   <= 1'b0;
            ramREN   <= 1'b1;
            ramaddr  <= iaddr;
            ramstore <= '0;
          end
        end
        DATA, INSTR: begin
          if (rs == ACCESS || rs == ERROR || wait_cnt == CNT_LAST) begin
            state    <= RESP;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            dHit     <= src_data;
            iHit     <= ~src_data;
            if (rs == ACCESS) begin
              if (!op_write) load_reg <= ramload;
            end else begin
              load_reg <= BAD_WORD;
              memErr   <= 1'b1;
            end
          end else if (wait_cnt != CNT_SAT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Responder for the datapath's memory requests: accepts instruction fetches (iREN) and data reads and writes (dREN/dWEN) from the control/datapath side. It serialises them onto the single-ported RAM interface and returns iHit/dHit with registered load data. It sits between the datapath and RAM and is the only block that drives the RAM request pins.

## Interface
- MAX_WAIT, 16: cycles allowed in one RAM access before timeout (≥2).
- BAD_WORD, 32'hBAD1BAD1: load value returned on error/timeout.
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- iREN  in  1  instruction fetch request, held until iHit.
- iaddr  in  32  fetch address.
- iload  out  32  fetched word, valid while iHit=1.
- iHit  out  1  one-cycle fetch completion pulse.
- dREN  in  1  data read request, held until dHit.
- dWEN  in  1  data write request, held until dHit; wins over dREN if both set.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dload  out  32  read word, valid while dHit=1.
- dHit  out  1  one-cycle data completion pulse.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when ramstate=ACCESS.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- memErr  out  1  sticky error flag, cleared only by RST.

## Operation
- FSM states: IDLE, DATA, INSTR, RESP.
- IDLE: if dWEN|dREN, latch op/daddr/dstore and go to DATA. Else if iREN, latch iaddr and go to INSTR. Data has strict priority.
- DATA/INSTR:
  - Drive ramREN/ramWEN, ramaddr and ramstore from the latched request only. No live input reaches the RAM pins.
  - INSTR is always a read with ramstore=0.
  - Wait counter starts at 0 on entry and increments each cycle.
- In DATA/INSTR, on ramstate=ACCESS: capture ramload into the load register for reads (register unchanged for writes), then go to RESP.
- In DATA/INSTR, on ramstate=ERROR, or when the counter reaches MAX_WAIT−1 without ACCESS: capture BAD_WORD, set memErr, go to RESP.
- RESP:
  - Pulse the hit matching the latched source (dHit or iHit, never both).
  - Present the load register on the matching load port; ram strobes are 0.
  - Go to IDLE unconditionally.
  - RESP gives the requester one cycle to drop or change its request before it can be re-sampled.
- A latched access always completes, even if the requester drops its request mid-access. The hit still pulses. A write is never cancelled.
- iload/dload show the load register at all times, but are valid only with the hit.
- Unlatched requests are ignored until IDLE.

## Timing
- Reset values:
  - state=IDLE, counter=0, load register=0, memErr=0.
  - All outputs 0: iHit, dHit, ramREN, ramWEN, ramaddr, ramstore, iload, dload.
- Latency from request sampled in IDLE (cycle 0):
  - RAM strobes assert in cycle 1.
  - If ACCESS arrives in cycle k≥1, the hit is high in cycle k+1.
  - Minimum 2 cycles; one request per 3 cycles at best.
- Simultaneous iREN and dREN in IDLE: data is served first. The fetch is taken on the IDLE following the data RESP.
- ERROR and counter expiry in the same cycle: treated as a single error.
- RST mid-access: returns to IDLE immediately, strobes drop asynchronously, and no hit is issued.
- Counter width is clog2(MAX_WAIT). It saturates and never wraps.

## Structure
- Add to cpu_types_pkg:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - arbstate_t enum (IDLE/DATA/INSTR/RESP).
  - BAD_WORD default constant.
- Single module; no sub-module needed. The wait counter stays inline.

## Test plan
- iREN=1, iaddr=0x40, RAM returns ACCESS in cycle 1 with ramload=0x2402000A -> ramREN=1 and ramaddr=0x40 in cycle 1; iHit=1 and iload=0x2402000A in cycle 2 only.
- dWEN=1 and iREN=1 together, daddr=0x80, dstore=0xDEADBEEF -> write issued first (ramWEN=1, ramstore=0xDEADBEEF); dHit pulses; then the fetch is issued; iHit follows 3+ cycles after dHit.
- dREN=1, ramstate=BUSY for 3 cycles then ACCESS with 0x1234 -> dHit exactly one cycle after ACCESS with dload=0x1234; memErr stays 0.
- dREN=1, ramstate stuck BUSY with MAX_WAIT=4 -> after 4 cycles RESP: dHit=1, dload=0xBAD1BAD1, memErr=1 sticky until RST.
- ramstate=ERROR on a fetch -> iHit=1, iload=0xBAD1BAD1, memErr=1.
- RST asserted mid-DATA -> strobes fall without waiting for a clock; no dHit; state=IDLE; a following request is served normally.
